// File: rtl/fifo_w.sv
// fifo_w: packs accepted bytes little-endian into 32-bit words behind a one-word holding register
// Ports: HCLK/HRESET clock and async active-high reset; status, shift_enable, data_out feed bytes;
//   flush pads a partial word; word_taken consumes HWDATA while word_ready is high;
//   full, byte_count and sticky overflow report fill state; transfer_data_complete_w pulses once per consumed word.
module fifo_w (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  status,
  input  logic        shift_enable,
  input  logic [7:0]  data_out,
  input  logic        flush,
  input  logic        word_taken,
  output logic [31:0] HWDATA,
  output logic        word_ready,
  output logic        full,
  output logic [1:0]  byte_count,
  output logic        transfer_data_complete_w,
  output logic        overflow
);
  typedef enum logic {EMPTY, VALID} hold_t;
  typedef enum logic {FILLING, PACKED} pack_t;
  hold_t hold_st;
  pack_t pack_st;
  logic [31:0] pack_reg, word;
  logic wr, acc, take, hold_free, done;
  always_comb begin
    wr = shift_enable && status == 2'b01;
    acc = wr && pack_st == FILLING;
    take = word_taken && hold_st == VALID;
    hold_free = hold_st == EMPTY || word_taken;
    // lanes at and above byte_count are kept zero, so a flushed word is already padded
    word = acc ? pack_reg | (32'(data_out) << {byte_count, 3'b000}) : pack_reg;
    done = (acc && byte_count == 2'd3) || (flush && pack_st == FILLING && (byte_count != 2'd0 || acc));
  end
  assign word_ready = hold_st == VALID;
  assign full = pack_st == PACKED;
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      hold_st <= EMPTY;
      pack_st <= FILLING;
      pack_reg <= '0;
      HWDATA <= '0;
      byte_count <= '0;
      transfer_data_complete_w <= 1'b0;
      overflow <= 1'b0;
    end else begin
      transfer_data_complete_w <= take;
      if (wr && pack_st == PACKED) overflow <= 1'b1;
      if (pack_st == PACKED) begin
        if (hold_free) begin
          HWDATA <= pack_reg;
          hold_st <= VALID;
          pack_st <= FILLING;
          pack_reg <= '0;
        end
      end else if (done) begin
        byte_count <= '0;
        if (hold_free) begin
          HWDATA <= word;
          hold_st <= VALID;
          pack_reg <= '0;
        end else begin
          pack_reg <= word;
          pack_st <= PACKED;
        end
      end else begin
        if (acc) begin
          pack_reg <= word;
          byte_count <= byte_count + 2'd1;
        end
        if (take) hold_st <= EMPTY;
      end
    end
endmodule

// File: tb/tb_fifo_w.sv
// tb_fifo_w: randomized and directed checks of fifo_w against a byte/word queue model
module tb_fifo_w;
  logic tb_HCLK = 1'b0;
  logic HRESET = 1'b1;
  logic [1:0] status = 2'b00;
  logic shift_enable = 1'b0;
  logic [7:0] data_out = 8'h00;
  logic flush = 1'b0;
  logic word_taken = 1'b0;
  logic [31:0] HWDATA;
  logic word_ready, full, transfer_data_complete_w, overflow;
  logic [1:0] byte_count;
  int total = 0;
  int passed = 0;
  logic [7:0] part[$];
  logic [31:0] words[$];
  logic [31:0] exp_q[$];
  logic m_ovf = 1'b0;
  logic m_pulse = 1'b0;

  fifo_w dut (
    .HCLK(tb_HCLK),
    .HRESET(HRESET),
    .status(status),
    .shift_enable(shift_enable),
    .data_out(data_out),
    .flush(flush),
    .word_taken(word_taken),
    .HWDATA(HWDATA),
    .word_ready(word_ready),
    .full(full),
    .byte_count(byte_count),
    .transfer_data_complete_w(transfer_data_complete_w),
    .overflow(overflow)
  );

  always #5 tb_HCLK = ~tb_HCLK;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
  endfunction

  // Model: bytes gather in part; completed words queue in words (holding first, then packed).
  task automatic model_step();
    logic [31:0] w;
    bit full_pre;
    full_pre = words.size() == 2;
    m_pulse = word_taken && words.size() > 0;
    if (m_pulse) void'(words.pop_front());
    if (shift_enable && status == 2'b01) begin
      if (full_pre) m_ovf = 1'b1;
      else part.push_back(data_out);
    end
    if (part.size() == 4 || (flush && part.size() > 0)) begin
      w = '0;
      foreach (part[i]) w[8*i +: 8] = part[i];
      words.push_back(w);
      exp_q.push_back(w);
      part.delete();
    end
  endtask

  task automatic cyc(input logic se, input logic [1:0] st, input logic [7:0] d, input logic fl, input logic wt);
    shift_enable = se;
    status = st;
    data_out = d;
    flush = fl;
    word_taken = wt;
    @(posedge tb_HCLK);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    #2;
    HRESET = 1'b1;
    part.delete();
    words.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_pulse = 1'b0;
    #1;
    chk("rst_HWDATA", HWDATA, 32'h0);
    chk("rst_word_ready", 32'(word_ready), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_byte_count", 32'(byte_count), 32'h0);
    chk("rst_complete", 32'(transfer_data_complete_w), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    {shift_enable, status, data_out, flush, word_taken} = '0;
    @(posedge tb_HCLK);
    #1;
    HRESET = 1'b0;
  endtask

  // Monitor: compares DUT outputs to the model each cycle and pops words on handshakes.
  always @(negedge tb_HCLK) if (!HRESET) begin
    chk("word_ready", 32'(word_ready), 32'(words.size() > 0));
    chk("full", 32'(full), 32'(words.size() == 2));
    chk("byte_count", 32'(byte_count), 32'(part.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("complete", 32'(transfer_data_complete_w), 32'(m_pulse));
    if (word_ready) begin
      if (exp_q.size() == 0) chk("HWDATA_unexpected", 32'(word_ready), 32'h0);
      else begin
        chk("HWDATA", HWDATA, exp_q[0]);
        if (word_taken) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] b4[4];
    b4 = '{8'h85, 8'h64, 8'h32, 8'h12};
    #3;
    do_reset();
    foreach (b4[i]) cyc(1, 2'b01, b4[i], 0, 0);
    chk("r31_data", HWDATA, 32'h12326485);
    chk("r31_ready", 32'(word_ready), 32'h1);
    chk("r31_count", 32'(byte_count), 32'h0);
    cyc(0, 2'b00, 8'h00, 0, 1);
    cyc(1, 2'b01, 8'h85, 0, 0);
    cyc(1, 2'b01, 8'h64, 0, 0);
    cyc(1, 2'b00, 8'hAA, 0, 0);
    cyc(1, 2'b10, 8'hBB, 0, 1);
    chk("r32_count", 32'(byte_count), 32'h2);
    cyc(1, 2'b01, 8'h32, 0, 0);
    cyc(1, 2'b01, 8'h12, 0, 0);
    chk("r32_data", HWDATA, 32'h12326485);
    cyc(0, 2'b00, 8'h00, 0, 1);
    do_reset();
    for (int i = 1; i <= 8; i++) cyc(1, 2'b01, 8'(i), 0, 0);
    chk("r33_full", 32'(full), 32'h1);
    chk("r33_data1", HWDATA, 32'h04030201);
    cyc(1, 2'b01, 8'h09, 0, 0);
    chk("r33_overflow", 32'(overflow), 32'h1);
    cyc(0, 2'b01, 8'h00, 0, 1);
    chk("r33_pulse", 32'(transfer_data_complete_w), 32'h1);
    chk("r33_data2", HWDATA, 32'h08070605);
    chk("r33_notfull", 32'(full), 32'h0);
    cyc(0, 2'b01, 8'h00, 0, 1);
    cyc(1, 2'b01, 8'h80, 0, 0);
    cyc(1, 2'b01, 8'h2F, 0, 0);
    cyc(0, 2'b00, 8'h00, 1, 0);
    chk("r34_data", HWDATA, 32'h00002F80);
    chk("r34_ready", 32'(word_ready), 32'h1);
    chk("r34_count", 32'(byte_count), 32'h0);
    cyc(0, 2'b00, 8'h00, 1, 1);
    for (int i = 1; i <= 4; i++) cyc(1, 2'b01, 8'(8'h10 * i + i), 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 2'b01, 8'(8'hAA + 8'h11 * i), 0, 0);
    cyc(1, 2'b01, 8'hDD, 0, 1);
    chk("r35_ready", 32'(word_ready), 32'h1);
    chk("r35_data", HWDATA, 32'hDDCCBBAA);
    chk("r35_pulse", 32'(transfer_data_complete_w), 32'h1);
    cyc(0, 2'b01, 8'h00, 0, 0);
    chk("r35_single_pulse", 32'(transfer_data_complete_w), 32'h0);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cyc($urandom_range(0, 3) != 0,
          $urandom_range(0, 4) == 0 ? 2'($urandom) : 2'b01,
          8'($urandom),
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 2) == 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
